vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Raster timing source for the VGA path. It runs free horizontal and vertical pixel counters and drives pixelX/pixelY to the background drawer and the object drawers. It also generates hsyncN, vsyncN, displayEn and startOfFrame, delayed by a parameterised number of registered stages so they line up with the registered BG_RGB at the VGA output.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525
PIPE_DELAY, 1, registered stages on sync/enable outputs; legal range 1..4

Ports:
clk  in  1  pixel clock; every rising edge is one pixel
resetN  in  1  asynchronous active-low reset
pixelX  out  11  current horizontal count, 0..H_TOTAL-1
pixelY  out  11  current vertical count, 0..V_TOTAL-1
displayEn  out  1  visible-area flag, delayed by PIPE_DELAY
hsyncN  out  1  horizontal sync, active low, delayed by PIPE_DELAY
vsyncN  out  1  vertical sync, active low, delayed by PIPE_DELAY
startOfFrame  out  1  one-clock pulse at pixel (0,0), delayed by PIPE_DELAY
frameCount  out  16  frames completed (see Optional Feature)

Behaviour:
- Reset (asynchronous, resetN=0):
  - pixelX=0, pixelY=0, frameCount=0.
  - All delay stages load the inactive value: hsyncN=1, vsyncN=1, displayEn=0, startOfFrame=0.
- Counters (registered):
  - pixelX increments every clk.
  - At pixelX==H_TOTAL-1, pixelX wraps to 0 on the same edge that pixelY increments.
  - At pixelX==H_TOTAL-1 and pixelY==V_TOTAL-1, both wrap to 0 on the same edge.
  - pixelX/pixelY are counter registers with no extra delay. The first post-reset clock shows (0,0).
- Raw flags, computed combinationally from the current counters:
  - hsRaw = pixelX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751]
  - vsRaw = pixelY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490,491]
  - deRaw = pixelX<H_VISIBLE && pixelY<V_VISIBLE
  - sofRaw = pixelX==0 && pixelY==0
- Delay line:
  - The bundle {~hsRaw, ~vsRaw, deRaw, sofRaw} passes through PIPE_DELAY flop stages. The outputs are the last stage.
  - With PIPE_DELAY=1, an output reflects the counter value of the previous clock. This matches the one-cycle BG_RGB register.
  - Latency is exactly PIPE_DELAY clocks for all four signals; relative alignment between them is never skewed.
- Reset mid-frame: counters and delay line clear immediately. No partial sync pulse is stretched; hsyncN/vsyncN return to 1 asynchronously.
- Widths: 11-bit counters cover H_TOTAL up to 2047. Compare constants are int-sized and truncated to 11 bits. Parameter sets with H_TOTAL or V_TOTAL > 2047 are illegal and flagged by an elaboration-time assertion, as is PIPE_DELAY outside 1..4.

Optional Feature:
Macro VGA_FRAME_CNT_EN.
- Defined: frameCount increments by 1 on the edge where both counters wrap to (0,0). It wraps 0xFFFF to 0x0000 and resets to 0. The increment is aligned to the counter wrap, not to the delayed startOfFrame.
- Undefined: frameCount is tied to 16'h0000 and no counter flops are inferred. The port remains present so instantiations are identical.

Decomposition:
- Package vga_pkg:
  - typedef pixel_coord_t = logic [10:0]
  - default 640x480@60 timing localparams
  - typedef struct packed sync_bundle_t {hsN, vsN, de, sof}
- One sub-module: vga_sync_delay. A parameterised DEPTH shift register of sync_bundle_t with asynchronous reset to the inactive bundle value. vga_timing_gen instantiates it with DEPTH=PIPE_DELAY.

Test Plan:
- Reset release, defaults: first clock pixelX=0, pixelY=0. One clock later (PIPE_DELAY=1): startOfFrame=1, displayEn=1, hsyncN=1, vsyncN=1. The next clock startOfFrame=0.
- Line timing: hsyncN low for exactly 96 clocks, first low clock one clock after pixelX==656. displayEn high for 640 clocks per visible line. Line period is 800 clocks.
- Frame timing: vsyncN low for exactly 2 lines (1600 clocks), starting the clock after pixelY==490,pixelX==0. startOfFrame period is 420000 clocks.
- Wrap: at (799,524) the next clock gives (0,0). At (799,10) the next clock gives (0,11).
- Mid-frame reset: assert resetN=0 at pixelX=700,pixelY=491 (hsyncN=0, vsyncN=0). Both go to 1 immediately, counters read 0, and the post-release sequence is identical to the first test.
- PIPE_DELAY=3 with VGA_FRAME_CNT_EN defined:
  - all delayed outputs lag the PIPE_DELAY=1 build by exactly 2 clocks;
  - frameCount reads 3 after 3×420000 clocks;
  - an undefined-macro build reads frameCount=0 throughout.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster timing for the VGA timing path.
// Contents: pixel coordinate / frame counter types, the sync bundle carried
// through the output delay line, its inactive value, and a window-compare helper.
package vga_pkg;

    localparam int unsigned COORD_W     = 11;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned COORD_MAX   = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0]     pixel_coord_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    // Default 640x480@60 timing
    localparam int unsigned DEF_H_VISIBLE  = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_VISIBLE  = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_PIPE_DELAY = 1;

    localparam int unsigned PIPE_DELAY_MIN = 1;
    localparam int unsigned PIPE_DELAY_MAX = 4;

    // Signals that must stay mutually aligned through the output pipeline
    typedef struct packed {
        logic hsN;
        logic vsN;
        logic de;
        logic sof;
    } sync_bundle_t;

    // Value every delay stage holds while in reset (syncs deasserted)
    localparam sync_bundle_t SYNC_IDLE = '{hsN: 1'b1, vsN: 1'b1, de: 1'b0, sof: 1'b0};

    // Inclusive range test on a coordinate
    function automatic logic in_window(input pixel_coord_t v,
                                       input pixel_coord_t lo,
                                       input pixel_coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus from the timing generator to the drawers and VGA output.
// Signals: pixelX/pixelY (live counters), displayEn, hsyncN, vsyncN,
// startOfFrame (pipeline-delayed), frameCount (completed frames).
// master = timing generator (drives all), slave = consumers.
interface vga_timing_gen_if;
    import vga_pkg::*;

    pixel_coord_t pixelX;
    pixel_coord_t pixelY;
    logic         displayEn;
    logic         hsyncN;
    logic         vsyncN;
    logic         startOfFrame;
    frame_cnt_t   frameCount;

    modport master (
        output pixelX,
        output pixelY,
        output displayEn,
        output hsyncN,
        output vsyncN,
        output startOfFrame,
        output frameCount
    );

    modport slave (
        input pixelX,
        input pixelY,
        input displayEn,
        input hsyncN,
        input vsyncN,
        input startOfFrame,
        input frameCount
    );

endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register for the sync bundle so hsync/vsync/enable/SOF
// leave together, aligned with the registered pixel colour.
// Ports: clk, resetN (async active-low, loads SYNC_IDLE into every stage),
// din (raw bundle), dout (bundle delayed by exactly DEPTH clocks).
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         resetN,
    input  sync_bundle_t din,
    output sync_bundle_t dout
);

    sync_bundle_t stages [DEPTH];

    // Shift chain; reset clears every stage so no partial sync pulse survives
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stages[i] <= SYNC_IDLE;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source.
// Ports: clk (pixel clock), resetN (async active-low), vga (master modport:
// pixelX/pixelY live counters, displayEn/hsyncN/vsyncN/startOfFrame delayed
// by PIPE_DELAY clocks, frameCount).
// Optional feature: define VGA_FRAME_CNT_EN to count completed frames on
// frameCount; otherwise frameCount is a constant zero and no flops exist.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic              clk,
    input  logic              resetN,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Compare constants, truncated to the counter width
    localparam pixel_coord_t H_LAST    = pixel_coord_t'(H_TOTAL - 1);
    localparam pixel_coord_t V_LAST    = pixel_coord_t'(V_TOTAL - 1);
    localparam pixel_coord_t H_VIS_END = pixel_coord_t'(H_VISIBLE);
    localparam pixel_coord_t V_VIS_END = pixel_coord_t'(V_VISIBLE);
    localparam pixel_coord_t H_SYNC_LO = pixel_coord_t'(H_VISIBLE + H_FP);
    localparam pixel_coord_t H_SYNC_HI = pixel_coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam pixel_coord_t V_SYNC_LO = pixel_coord_t'(V_VISIBLE + V_FP);
    localparam pixel_coord_t V_SYNC_HI = pixel_coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Reject parameter sets the 11-bit counters or the delay line cannot hold
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end
    if (PIPE_DELAY < PIPE_DELAY_MIN || PIPE_DELAY > PIPE_DELAY_MAX) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be within 1..4");
    end

    pixel_coord_t h_cnt;
    pixel_coord_t v_cnt;
    logic         line_end;
    logic         frame_end;
    sync_bundle_t raw_bundle;
    sync_bundle_t dly_bundle;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    // Pixel/line counters; both wrap on the same edge at the frame corner
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + pixel_coord_t'(1);
        end else begin
            h_cnt <= h_cnt + pixel_coord_t'(1);
        end
    end

    // Raw timing flags decoded from the current counter values
    always_comb begin
        raw_bundle     = SYNC_IDLE;
        raw_bundle.hsN = ~in_window(h_cnt, H_SYNC_LO, H_SYNC_HI);
        raw_bundle.vsN = ~in_window(v_cnt, V_SYNC_LO, V_SYNC_HI);
        raw_bundle.de  = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        raw_bundle.sof = (h_cnt == '0) && (v_cnt == '0);
    end

    // Matches the colour pipeline latency so syncs stay aligned with BG_RGB
    vga_sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .din    (raw_bundle),
        .dout   (dly_bundle)
    );

`ifdef VGA_FRAME_CNT_EN
    frame_cnt_t frame_cnt;

    // Counts on the counter wrap itself, not on the delayed startOfFrame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + frame_cnt_t'(1);
        end
    end

    assign vga.frameCount = frame_cnt;
`else
    assign vga.frameCount = '0;
`endif

    assign vga.pixelX       = h_cnt;
    assign vga.pixelY       = v_cnt;
    assign vga.hsyncN       = dly_bundle.hsN;
    assign vga.vsyncN       = dly_bundle.vsN;
    assign vga.displayEn    = dly_bundle.de;
    assign vga.startOfFrame = dly_bundle.sof;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance (PIPE_DELAY=1) plus two
// reduced-raster instances (25x13, PIPE_DELAY=1 and 3), all checked every
// cycle against an arithmetic model keyed on clocks since reset release.
module tb_vga_timing_gen;

    localparam int unsigned S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int unsigned S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 2;

    logic        clk;
    logic        resetN;
    int unsigned t;
    int unsigned checks;
    int unsigned errors;
    logic        cmp_en;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen dut_a (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_a)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_VISIBLE (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .PIPE_DELAY (1)
    ) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_b)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_VISIBLE (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .PIPE_DELAY (3)
    ) dut_c (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since the last reset release
    always @(posedge clk or negedge resetN) begin
        if (!resetN) t <= 0;
        else         t <= t + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    // Expected outputs from raster arithmetic: position = time mod line/frame,
    // delayed flags = flags of the position PIPE clocks earlier (idle before that)
    task automatic cmp_inst(input string tag, input int unsigned p,
                            input int unsigned hv, input int unsigned hf,
                            input int unsigned hs, input int unsigned hb,
                            input int unsigned vv, input int unsigned vf,
                            input int unsigned vs, input int unsigned vb,
                            input logic [10:0] ax, input logic [10:0] ay,
                            input logic ahs, input logic avs, input logic ade,
                            input logic asof, input logic [15:0] afc);
        int unsigned ht, vt, x, y, tt, fc;
        logic ehs, evs, ede, esof;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        ehs = 1'b1; evs = 1'b1; ede = 1'b0; esof = 1'b0;
        if (t >= p) begin
            tt   = t - p;
            x    = tt % ht;
            y    = (tt / ht) % vt;
            ehs  = !(x >= hv + hf && x < hv + hf + hs);
            evs  = !(y >= vv + vf && y < vv + vf + vs);
            ede  = (x < hv) && (y < vv);
            esof = (x == 0) && (y == 0);
        end
`ifdef VGA_FRAME_CNT_EN
        fc = (t / (ht * vt)) % 65536;
`else
        fc = 0;
`endif
        check({tag, ".pixelX"},       32'(ax),   t % ht);
        check({tag, ".pixelY"},       32'(ay),   (t / ht) % vt);
        check({tag, ".hsyncN"},       32'(ahs),  32'(ehs));
        check({tag, ".vsyncN"},       32'(avs),  32'(evs));
        check({tag, ".displayEn"},    32'(ade),  32'(ede));
        check({tag, ".startOfFrame"}, 32'(asof), 32'(esof));
        check({tag, ".frameCount"},   32'(afc),  fc);
    endtask

    // Continuous model comparison, sampled on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst("a", 1, 640, 16, 96, 48, 480, 10, 2, 33,
                     if_a.pixelX, if_a.pixelY, if_a.hsyncN, if_a.vsyncN,
                     if_a.displayEn, if_a.startOfFrame, if_a.frameCount);
            cmp_inst("b", 1, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                     if_b.pixelX, if_b.pixelY, if_b.hsyncN, if_b.vsyncN,
                     if_b.displayEn, if_b.startOfFrame, if_b.frameCount);
            cmp_inst("c", 3, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                     if_c.pixelX, if_c.pixelY, if_c.hsyncN, if_c.vsyncN,
                     if_c.displayEn, if_c.startOfFrame, if_c.frameCount);
        end
    end

    // Hand-computed literal expectations at fixed clock counts
    task automatic directed_run(input int unsigned stop_t);
        int unsigned de_cnt = 0;
        int unsigned hs_low = 0;
        int unsigned guard  = 0;
        logic [15:0] fc2, fc3;
`ifdef VGA_FRAME_CNT_EN
        fc2 = 16'd2; fc3 = 16'd3;
`else
        fc2 = 16'd0; fc3 = 16'd0;
`endif
        while (t < stop_t && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (t >= 1 && t <= 800) begin
                if (if_a.displayEn) de_cnt++;
                if (!if_a.hsyncN)   hs_low++;
            end
            case (t)
                1: begin
                    check("lit.a.sof_t1",  32'(if_a.startOfFrame), 1);
                    check("lit.a.de_t1",   32'(if_a.displayEn), 1);
                    check("lit.a.hs_t1",   32'(if_a.hsyncN), 1);
                    check("lit.a.vs_t1",   32'(if_a.vsyncN), 1);
                    check("lit.c.sof_t1",  32'(if_c.startOfFrame), 0);
                end
                2: begin
                    check("lit.a.sof_t2",  32'(if_a.startOfFrame), 0);
                    check("lit.c.sof_t2",  32'(if_c.startOfFrame), 0);
                end
                3:    check("lit.c.sof_t3",  32'(if_c.startOfFrame), 1);
                246: begin
                    check("lit.b.hs_t246", 32'(if_b.hsyncN), 0);
                    check("lit.b.vs_t246", 32'(if_b.vsyncN), 0);
                end
                324: begin
                    check("lit.b.x_corner", 32'(if_b.pixelX), 24);
                    check("lit.b.y_corner", 32'(if_b.pixelY), 12);
                end
                325: begin
                    check("lit.b.x_wrap", 32'(if_b.pixelX), 0);
                    check("lit.b.y_wrap", 32'(if_b.pixelY), 0);
                end
                656:  check("lit.a.hs_t656", 32'(if_a.hsyncN), 1);
                657:  check("lit.a.hs_t657", 32'(if_a.hsyncN), 0);
                752:  check("lit.a.hs_t752", 32'(if_a.hsyncN), 0);
                753:  check("lit.a.hs_t753", 32'(if_a.hsyncN), 1);
                800: begin
                    check("lit.a.de_per_line", de_cnt, 640);
                    check("lit.a.hs_low_len",  hs_low, 96);
                end
                974:  check("lit.c.fc_t974", 32'(if_c.frameCount), 32'(fc2));
                975:  check("lit.c.fc_t975", 32'(if_c.frameCount), 32'(fc3));
                8799: begin
                    check("lit.a.x_t8799", 32'(if_a.pixelX), 799);
                    check("lit.a.y_t8799", 32'(if_a.pixelY), 10);
                end
                8800: begin
                    check("lit.a.x_t8800", 32'(if_a.pixelX), 0);
                    check("lit.a.y_t8800", 32'(if_a.pixelY), 11);
                end
                default: ;
            endcase
        end
        check("run_bound", t, stop_t);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        resetN = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.a.pixelX",     32'(if_a.pixelX), 0);
        check("rst.a.hsyncN",     32'(if_a.hsyncN), 1);
        check("rst.c.vsyncN",     32'(if_c.vsyncN), 1);
        check("rst.a.displayEn",  32'(if_a.displayEn), 0);
        check("rst.c.frameCount", 32'(if_c.frameCount), 0);

        // First run up to a point inside both syncs of the small raster
        resetN = 1'b1;
        check("rel.a.pixelX_t0", 32'(if_a.pixelX), 0);
        check("rel.a.sof_t0",    32'(if_a.startOfFrame), 0);
        directed_run(246);

        // Mid-frame reset while hsyncN and vsyncN are both low
        #2 resetN = 1'b0;
        #1;
        check("mid.b.hsyncN", 32'(if_b.hsyncN), 1);
        check("mid.b.vsyncN", 32'(if_b.vsyncN), 1);
        check("mid.b.pixelX", 32'(if_b.pixelX), 0);
        check("mid.b.pixelY", 32'(if_b.pixelY), 0);
        check("mid.a.pixelX", 32'(if_a.pixelX), 0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        directed_run(8800);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
